// File: rtl/ifu_pkg.sv
// Shared fetch-unit types: instruction/PC widths and the prefetch queue entry.
// Used by instr_prefetch_queue and its interface.
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ifq_entry_t;

  // PC of lane `lane` within a burst whose lane 0 sits at `base`; wraps mod 2^32.
  function automatic logic [PC_W-1:0] lane_pc(input logic [PC_W-1:0] base,
                                              input int unsigned      lane);
    return base + PC_W'(PC_STEP * lane);
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Burst-write / multi-lane-read bus of the instruction prefetch queue.
// Error outputs exist only when IPQ_ERR_CHECK_EN is defined.
interface instr_prefetch_queue_if #(
  parameter int DEPTH   = 8,
  parameter int BURST_W = 4,
  parameter int READ_W  = 2
);
  import ifu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(BURST_W + 1);
  localparam int RT_W  = $clog2(READ_W + 1);

  logic                       flush;
  logic                       wr_en;
  logic [BURST_W*INSTR_W-1:0] wr_data;
  logic [PC_W-1:0]            wr_pc;
  logic [WC_W-1:0]            wr_count;
  logic                       wr_ready;
  logic [RT_W-1:0]            rd_take;
  logic [READ_W*INSTR_W-1:0]  rd_instr;
  logic [READ_W*PC_W-1:0]     rd_pc;
  logic [READ_W-1:0]          rd_valid;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           free;
`ifdef IPQ_ERR_CHECK_EN
  logic                       err_overflow;
  logic                       err_underflow;
`endif

  modport master (
    output flush, wr_en, wr_data, wr_pc, wr_count, rd_take,
    input  wr_ready, rd_instr, rd_pc, rd_valid, count, free
`ifdef IPQ_ERR_CHECK_EN
    , input err_overflow, err_underflow
`endif
  );

  modport slave (
    input  flush, wr_en, wr_data, wr_pc, wr_count, rd_take,
    output wr_ready, rd_instr, rd_pc, rd_valid, count, free
`ifdef IPQ_ERR_CHECK_EN
    , output err_overflow, err_underflow
`endif
  );

endinterface

// File: rtl/ipq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the prefetch queue: write acceptance,
// read clamping and pointer wrap. Sticky error flags when IPQ_ERR_CHECK_EN is defined.
module ipq_ptr_ctrl #(
  parameter int DEPTH   = 8,
  parameter int BURST_W = 4,
  parameter int READ_W  = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              wr_en,
  input  logic [$clog2(BURST_W+1)-1:0]      wr_count,
  input  logic [$clog2(READ_W+1)-1:0]       rd_take,
  output logic                              wr_accept,
  output logic [$clog2(DEPTH)-1:0]          head,
  output logic [$clog2(DEPTH)-1:0]          tail,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic [$clog2(DEPTH+1)-1:0]        free,
  output logic                              wr_ready
`ifdef IPQ_ERR_CHECK_EN
  , output logic                            err_overflow
  , output logic                            err_underflow
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] free_reg, free_next;
  logic             wr_ready_reg, wr_ready_next;
  logic [CNT_W-1:0] wr_add, rd_req, taken;

  assign wr_add = CNT_W'(wr_count);
  assign rd_req = CNT_W'(rd_take);

  // Acceptance is judged on registered free, i.e. before any same-cycle read.
  assign wr_accept = wr_en && !flush && (wr_add != '0) && (wr_add <= free_reg);
  assign taken     = (rd_req > count_reg) ? count_reg : rd_req;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head_reg + PTR_W'(taken);
      tail_next  = tail_reg + (wr_accept ? PTR_W'(wr_add) : '0);
      count_next = count_reg + (wr_accept ? wr_add : '0) - taken;
    end
    free_next     = CNT_W'(DEPTH) - count_next;
    wr_ready_next = (free_next >= CNT_W'(BURST_W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      free_reg     <= CNT_W'(DEPTH);
      wr_ready_reg <= 1'b1;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      free_reg     <= free_next;
      wr_ready_reg <= wr_ready_next;
    end
  end

  assign head     = head_reg;
  assign tail     = tail_reg;
  assign count    = count_reg;
  assign free     = free_reg;
  assign wr_ready = wr_ready_reg;

`ifdef IPQ_ERR_CHECK_EN
  logic err_overflow_reg, err_underflow_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else if (flush) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      if (wr_en && !wr_accept) err_overflow_reg  <= 1'b1;
      if (rd_req > count_reg)  err_underflow_reg <= 1'b1;
    end
  end

  assign err_overflow  = err_overflow_reg;
  assign err_underflow = err_underflow_reg;
`endif

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: burst writes of up to BURST_W instructions, READ_W-lane
// combinational read from head. Optional sticky error outputs under IPQ_ERR_CHECK_EN.
module instr_prefetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int BURST_W = 4,
  parameter int READ_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_prefetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(BURST_W + 1);

  logic             wr_accept;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_q, free_q;
  logic             wr_ready_q;

  ipq_ptr_ctrl #(
    .DEPTH   (DEPTH),
    .BURST_W (BURST_W),
    .READ_W  (READ_W)
  ) u_ptr_ctrl (
    .clk           (clk),
    .reset         (reset),
    .flush         (bus.flush),
    .wr_en         (bus.wr_en),
    .wr_count      (bus.wr_count),
    .rd_take       (bus.rd_take),
    .wr_accept     (wr_accept),
    .head          (head),
    .tail          (tail),
    .count         (count_q),
    .free          (free_q),
    .wr_ready      (wr_ready_q)
`ifdef IPQ_ERR_CHECK_EN
    , .err_overflow  (bus.err_overflow)
    , .err_underflow (bus.err_underflow)
`endif
  );

  // Storage is not reset: pointers alone define which entries are live.
  ifq_entry_t mem [DEPTH];

  ifq_entry_t       wr_entry   [BURST_W];
  logic [PTR_W-1:0] wr_addr    [BURST_W];
  logic [BURST_W-1:0] wr_lane_en;

  genvar gi;
  generate
    for (gi = 0; gi < BURST_W; gi++) begin : g_wr_lane
      assign wr_entry[gi] = '{instr: bus.wr_data[gi*INSTR_W +: INSTR_W],
                              pc:    lane_pc(bus.wr_pc, gi)};
      assign wr_addr[gi]    = tail + PTR_W'(gi);
      assign wr_lane_en[gi] = wr_accept && (bus.wr_count > WC_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < BURST_W; k++) begin
      if (wr_lane_en[k]) mem[wr_addr[k]] <= wr_entry[k];
    end
  end

  logic [READ_W*INSTR_W-1:0] rd_instr_w;
  logic [READ_W*PC_W-1:0]    rd_pc_w;
  logic [READ_W-1:0]         rd_valid_w;

  generate
    for (gi = 0; gi < READ_W; gi++) begin : g_rd_lane
      logic [PTR_W-1:0] rd_addr;
      assign rd_addr        = head + PTR_W'(gi);
      assign rd_valid_w[gi] = (count_q > CNT_W'(gi));
      assign rd_instr_w[gi*INSTR_W +: INSTR_W] = rd_valid_w[gi] ? mem[rd_addr].instr : '0;
      assign rd_pc_w[gi*PC_W +: PC_W]          = rd_valid_w[gi] ? mem[rd_addr].pc    : '0;
    end
  endgenerate

  assign bus.rd_instr = rd_instr_w;
  assign bus.rd_pc    = rd_pc_w;
  assign bus.rd_valid = rd_valid_w;
  assign bus.count    = count_q;
  assign bus.free     = free_q;
  assign bus.wr_ready = wr_ready_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed + short random bench for instr_prefetch_queue with a queue scoreboard.
// Error-flag checks compile in only when IPQ_ERR_CHECK_EN is defined.
module tb_instr_prefetch_queue;
  import ifu_pkg::*;

  localparam int DEPTH   = 8;
  localparam int BURST_W = 4;
  localparam int READ_W  = 2;
  localparam int WC_W    = $clog2(BURST_W + 1);
  localparam int RT_W    = $clog2(READ_W + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_prefetch_queue_if #(.DEPTH(DEPTH), .BURST_W(BURST_W), .READ_W(READ_W)) bus ();

  instr_prefetch_queue #(.DEPTH(DEPTH), .BURST_W(BURST_W), .READ_W(READ_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  logic [63:0] exp_q[$];   // {instr, pc}, oldest first
  bit          exp_ovf, exp_unf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz = exp_q.size();
    check({tag, ".count"},    64'(bus.count),    64'(sz));
    check({tag, ".free"},     64'(bus.free),     64'(DEPTH - sz));
    check({tag, ".wr_ready"}, 64'(bus.wr_ready), 64'((DEPTH - sz) >= BURST_W));
    for (int i = 0; i < READ_W; i++) begin
      check($sformatf("%s.valid%0d", tag, i), 64'(bus.rd_valid[i]), 64'(i < sz));
      check($sformatf("%s.instr%0d", tag, i), 64'(bus.rd_instr[i*32 +: 32]),
            (i < sz) ? 64'(exp_q[i][63:32]) : 64'd0);
      check($sformatf("%s.pc%0d", tag, i), 64'(bus.rd_pc[i*32 +: 32]),
            (i < sz) ? 64'(exp_q[i][31:0]) : 64'd0);
    end
`ifdef IPQ_ERR_CHECK_EN
    check({tag, ".err_ovf"}, 64'(bus.err_overflow),  64'(exp_ovf));
    check({tag, ".err_unf"}, 64'(bus.err_underflow), 64'(exp_unf));
`endif
    txn++;
    $display("txn %0d %s: count=%0d free=%0d wr_ready=%0b rd_valid=%b", txn, tag,
             bus.count, bus.free, bus.wr_ready, bus.rd_valid);
  endtask

  task automatic idle_inputs();
    bus.flush    = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_count = '0;
    bus.wr_pc    = '0;
    bus.wr_data  = '0;
    bus.rd_take  = '0;
  endtask

  // One clock of stimulus; the scoreboard is updated from the pre-edge model state.
  task automatic drive(input bit fl, input bit we, input int wc, input logic [31:0] pc,
                       input logic [31:0] base, input int take, input string tag);
    int  sz     = exp_q.size();
    bit  acc;
    int  tk;
    bus.flush    = fl;
    bus.wr_en    = we;
    bus.wr_count = WC_W'(wc);
    bus.wr_pc    = pc;
    for (int k = 0; k < BURST_W; k++) bus.wr_data[k*32 +: 32] = base + 32'(k);
    bus.rd_take  = RT_W'(take);
    acc = we && !fl && (wc >= 1) && (wc <= DEPTH - sz);
    tk  = (take > sz) ? sz : take;
    if (fl) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (we && !acc) exp_ovf = 1'b1;
      if (take > sz)  exp_unf = 1'b1;
      repeat (tk) void'(exp_q.pop_front());
      if (acc) for (int k = 0; k < wc; k++) exp_q.push_back({base + 32'(k), pc + 32'(4 * k)});
    end
    @(posedge clk);
    #1;
    idle_inputs();
    check_state(tag);
  endtask

  initial begin
    idle_inputs();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("rst_held");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("after_reset");

    // First burst is visible one cycle later, oldest in lane 0.
    drive(0, 1, 4, 32'h100, 32'hA0, 0, "burst_a");
    check("burst_a.lit_instr0", 64'(bus.rd_instr[31:0]),  64'hA0);
    check("burst_a.lit_pc1",    64'(bus.rd_pc[63:32]),    64'h104);

    drive(0, 1, 4, 32'h110, 32'hB0, 0, "burst_b");
    drive(0, 1, 4, 32'h120, 32'hC0, 0, "overflow_reject");
    check("overflow.lit_count", 64'(bus.count), 64'd8);
    check("overflow.lit_ready", 64'(bus.wr_ready), 64'd0);

    drive(0, 0, 0, 32'h0,   32'h0,  2, "take2");
    drive(0, 1, 3, 32'h130, 32'hD0, 0, "wr3_free2_reject");
    drive(0, 1, 2, 32'h300, 32'hD8, 0, "wr2_free2_accept");
    drive(0, 1, 0, 32'h340, 32'hE8, 0, "wr_count0_reject");
    drive(1, 0, 0, 32'h0,   32'h0,  0, "flush");

    // Fill 6, drain 2 per cycle, then a burst that wraps the tail 6 -> 2.
    drive(0, 1, 4, 32'h400, 32'h40, 0, "fill4");
    drive(0, 1, 2, 32'h410, 32'h44, 0, "fill6");
    drive(0, 0, 0, 32'h0,   32'h0,  2, "drain_a");
    drive(0, 0, 0, 32'h0,   32'h0,  2, "drain_b");
    drive(0, 0, 0, 32'h0,   32'h0,  2, "drain_c");
    drive(0, 1, 4, 32'h200, 32'h50, 0, "wrap_burst");
    check("wrap.lit_pc0", 64'(bus.rd_pc[31:0]),  64'h200);
    check("wrap.lit_pc1", 64'(bus.rd_pc[63:32]), 64'h204);
    drive(0, 1, 4, 32'h600, 32'h60, 2, "wr_and_take");
    check("wrap.lit_pc2", 64'(bus.rd_pc[31:0]),  64'h208);
    check("wrap.lit_pc3", 64'(bus.rd_pc[63:32]), 64'h20C);
    drive(0, 0, 0, 32'h0,   32'h0,  2, "drain_d");

    // Underflow clamp: one entry, ask for two.
    drive(1, 0, 0, 32'h0,   32'h0,  0, "flush2");
    drive(0, 1, 1, 32'h700, 32'h70, 0, "one_entry");
    drive(0, 0, 0, 32'h0,   32'h0,  2, "clamp_take");
    check("clamp.lit_valid", 64'(bus.rd_valid), 64'd0);

    // Flush overrides a same-cycle write and read.
    drive(0, 1, 4, 32'h800, 32'h80, 0, "fill4b");
    drive(0, 1, 1, 32'h810, 32'h84, 0, "fill5");
    drive(1, 1, 3, 32'h900, 32'h90, 2, "flush_wr_rd");
    check("flush.lit_free", 64'(bus.free), 64'd8);

    // PC generation wraps modulo 2^32 across lanes.
    drive(0, 1, 4, 32'hFFFF_FFF8, 32'hF0, 0, "pc_wrap");
    drive(0, 0, 0, 32'h0, 32'h0, 2, "pc_wrap_take");
    check("pcwrap.lit_pc0", 64'(bus.rd_pc[31:0]), 64'h0);

    // Short random run against the scoreboard.
    for (int n = 0; n < 40; n++) begin
      drive(($urandom_range(15) == 0), $urandom_range(1), int'($urandom_range(BURST_W)),
            $urandom, $urandom, int'($urandom_range(READ_W)), $sformatf("rand%0d", n));
    end

    // Asynchronous reset mid-operation: takes effect without a clock edge.
    drive(0, 1, 3, 32'hA00, 32'h33, 0, "pre_reset");
    bus.wr_en    = 1'b1;
    bus.wr_count = WC_W'(2);
    bus.rd_take  = RT_W'(1);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_state("async_reset");
    @(posedge clk);
    #1;
    check_state("reset_edge");
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
